// File: rtl/fsk_pkg.sv
// Shared FSK definitions: symbol type, modulator periods, demodulator class thresholds and FSM states.
package fsk_pkg;
  typedef logic [1:0] sym_t;

  localparam int PER_W    = 8;
  localparam int PER_SYM0 = 2;
  localparam int PER_SYM1 = 4;
  localparam int PER_SYM2 = 8;
  localparam int PER_SYM3 = 16;

  // Thresholds sit roughly midway between neighbouring nominal periods
  localparam int CLS_TH0 = 3;
  localparam int CLS_TH1 = 6;
  localparam int CLS_TH2 = 12;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  function automatic sym_t classify(input logic [PER_W-1:0] p);
    if (int'(p) <= CLS_TH0)      return 2'd0;
    else if (int'(p) <= CLS_TH1) return 2'd1;
    else if (int'(p) <= CLS_TH2) return 2'd2;
    else                         return 2'd3;
  endfunction
endpackage

// File: rtl/fsk_period_meter.sv
// Synchronises the FSK input, flags rising edges and measures rise-to-rise period.
// rise is combinational from the 2nd/3rd flops; period saturates at TIMEOUT (timeout high).
module fsk_period_meter
  import fsk_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             rise,
  output logic [PER_W-1:0] period,
  output logic             timeout
);
  logic             s1, s2, s3;
  logic [PER_W-1:0] per_cnt;

  assign rise    = s2 & ~s3;
  assign period  = per_cnt;
  assign timeout = (per_cnt == PER_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      per_cnt <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
      if (rise)
        per_cnt <= PER_W'(1);
      else if (!timeout)
        per_cnt <= per_cnt + PER_W'(1);
    end
  end
endmodule

// File: rtl/fsk_demodulator.sv
// FSK demodulator: classifies input periods into symbols, debounced over MATCH_CNT periods.
// Outputs update 3 edges after the input edge; optional err_cnt with DEMOD_ERRCNT_EN.
module fsk_demodulator
  import fsk_pkg::*;
#(
  parameter int MATCH_CNT = 2,
  parameter int TIMEOUT   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [1:0] sym,
  output logic       sym_valid,
  output logic       lock
`ifdef DEMOD_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  logic             rise;
  logic             timeout;
  logic [PER_W-1:0] period;
  state_t           state;
  sym_t             cand;
  sym_t             cls;
  logic [2:0]       match;
  logic [3:0]       match_nxt;
  logic             locked_once;

  fsk_period_meter #(.TIMEOUT(TIMEOUT)) u_meter (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .rise    (rise),
    .period  (period),
    .timeout (timeout)
  );

  assign cls       = classify(period);
  assign match_nxt = (cls == cand) ? {1'b0, match} + 4'd1 : 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      cand        <= '0;
      match       <= '0;
      sym         <= '0;
      sym_valid   <= 1'b0;
      lock        <= 1'b0;
      locked_once <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      case (state)
        SEARCH: begin
          // first edge only starts the period counter
          if (rise) begin
            state <= ACQUIRE;
            match <= '0;
          end
        end
        ACQUIRE: begin
          if (rise) begin
            cand  <= cls;
            match <= match_nxt[2:0];
            if (match_nxt >= 4'(MATCH_CNT)) begin
              state       <= LOCKED;
              sym         <= cls;
              lock        <= 1'b1;
              sym_valid   <= !locked_once || (cls != sym);
              locked_once <= 1'b1;
            end
          end else if (timeout) begin
            state <= SEARCH;
          end
        end
        LOCKED: begin
          if (rise) begin
            if (cls != sym) begin
              state <= ACQUIRE;
              cand  <= cls;
              match <= 3'd1;
              lock  <= 1'b0;
            end
          end else if (timeout) begin
            state <= SEARCH;
            lock  <= 1'b0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef DEMOD_ERRCNT_EN
  logic err_evt;
  assign err_evt = (state == LOCKED) && (rise ? (cls != sym) : timeout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_cnt <= 8'd0;
    else if (err_evt && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule
